// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: SR, Cause, EPC, PRId, exception/interrupt entry.
// Define CP0_TIMER_EN to add Count/Compare and the timer interrupt on IP[15].
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2020
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic        ExcReq,
  input  logic [31:0] EPCIn,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exccode;
  logic [31:0] epc;
  logic        tpend;
  logic [5:0]  hw_eff;
  logic        take;
  logic        wr;
  logic        wr_sr;
  logic        wr_epc;

  assign hw_eff = HWInt | {tpend, 5'b0};
  assign IntReq = (|(hw_eff & im)) & ie & ~exl;
  assign take   = IntReq | (ExcReq & ~exl);

  // A taken exception/interrupt swallows any mtc0 in the same cycle
  assign wr     = WE & ~take;
  assign wr_sr  = wr & (A2 == 5'd12);
  assign wr_epc = wr & (A2 == 5'd14);

  assign EPCOut = epc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      im      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      ip      <= '0;
      exccode <= '0;
      epc     <= '0;
    end else begin
      ip <= hw_eff;
      if (take) begin
        exl     <= 1'b1;
        epc     <= EPCIn;
        bd      <= BDIn;
        exccode <= IntReq ? 5'd0 : ExcCodeIn;
      end else begin
        if (wr_sr) begin
          im  <= DIn[15:10];
          exl <= DIn[1];
          ie  <= DIn[0];
        end
        if (wr_epc)
          epc <= DIn;
        if (EXLClr)
          exl <= 1'b0;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        wr_cnt;
  logic        wr_cmp;

  assign wr_cnt = wr & (A2 == 5'd9);
  assign wr_cmp = wr & (A2 == 5'd11);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      compare <= '0;
      tpend   <= 1'b0;
    end else begin
      count <= wr_cnt ? DIn : count + 32'd1;
      if (wr_cmp)
        compare <= DIn;
      if (wr_cmp)
        tpend <= 1'b0;
      else if (count == compare && compare != '0)
        tpend <= 1'b1;
    end
  end
`else
  assign tpend = 1'b0;
`endif

  always_comb begin
    DOut = '0;
    case (A1)
      5'd12: DOut = {16'h0, im, 8'h0, exl, ie};
      5'd13: DOut = {bd, 15'h0, ip, 3'h0, exccode, 2'h0};
      5'd14: DOut = epc;
      5'd15: DOut = PRID_VALUE;
`ifdef CP0_TIMER_EN
      5'd9:  DOut = count;
      5'd11: DOut = compare;
`endif
      default: DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed-vector bench for cp0_regfile.
// Timer checks are compiled only when CP0_TIMER_EN is defined.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE;
  logic        ExcReq;
  logic [31:0] EPCIn;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  int n_chk = 0;
  int n_err = 0;

  always #50 clk = ~clk;

  cp0_regfile dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .ExcReq    (ExcReq),
    .EPCIn     (EPCIn),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .IntReq    (IntReq),
    .EPCOut    (EPCOut),
    .DOut      (DOut)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a,
                    input logic [31:0] exp,
                    input string tag);
    A1 = a;
    #1;
    chk(tag, DOut, exp);
  endtask

  task automatic idle();
    WE = 0; ExcReq = 0; EXLClr = 0;
    BDIn = 0; ExcCodeIn = 5'd0;
  endtask

  task automatic mtc0(input logic [4:0] a,
                      input logic [31:0] d);
    WE = 1; A2 = a; DIn = d;
    tick();
    WE = 0;
  endtask

  initial begin
    reset_n = 0; A1 = 0; A2 = 0; DIn = 0;
    EPCIn = 0; HWInt = 0;
    idle();
    tick(); tick();
    reset_n = 1;

    rd(5'd12, 32'h0, "reset_sr");
    rd(5'd13, 32'h0, "reset_cause");
    rd(5'd14, 32'h0, "reset_epc");
    rd(5'd15, 32'h0000_2020, "prid");
    chk("reset_intreq", {31'h0, IntReq}, 32'h0);

    // interrupt entry
    mtc0(5'd12, 32'h0000_FC01);
    rd(5'd12, 32'h0000_FC01, "sr_write");
    HWInt = 6'b000001; EPCIn = 32'h0000_1000;
    #1;
    chk("int_req", {31'h0, IntReq}, 32'h1);
    tick();
    HWInt = 6'b0;
    rd(5'd12, 32'h0000_FC03, "int_sr_exl");
    rd(5'd13, 32'h0000_0400, "int_cause");
    chk("int_epc", EPCOut, 32'h0000_1000);
    chk("int_masked", {31'h0, IntReq}, 32'h0);

    // ExcReq ignored while EXL=1
    ExcReq = 1; ExcCodeIn = 5'd4; EPCIn = 32'h5555;
    tick();
    idle();
    rd(5'd14, 32'h0000_1000, "exl_hold_epc");
    rd(5'd13, 32'h0, "exl_hold_cause");
    EXLClr = 1;
    tick();
    idle();
    rd(5'd12, 32'h0000_FC01, "eret_clr");

    // synchronous exception in delay slot
    ExcReq = 1; ExcCodeIn = 5'd4; BDIn = 1;
    EPCIn = 32'h0000_3004;
    tick();
    idle();
    rd(5'd13, 32'h8000_0010, "exc_cause");
    rd(5'd14, 32'h0000_3004, "exc_epc");
    rd(5'd12, 32'h0000_FC03, "exc_sr");

    // eret plus mtc0 SR setting EXL: EXL still clears
    EXLClr = 1;
    mtc0(5'd12, 32'h0000_0003);
    idle();
    rd(5'd12, 32'h0000_0001, "eret_mtc0");
    mtc0(5'd12, 32'h0000_FC01);

    // no write bypass on DOut/EPCOut
    WE = 1; A2 = 5'd14; DIn = 32'hABCD;
    EPCIn = 32'h9999;
    rd(5'd14, 32'h0000_3004, "no_bypass");
    tick();
    WE = 0;
    rd(5'd14, 32'h0000_ABCD, "epc_write");
    chk("epcout", EPCOut, 32'h0000_ABCD);

    // read-only / unimplemented
    mtc0(5'd13, 32'hFFFF_FFFF);
    mtc0(5'd15, 32'h0);
    rd(5'd13, 32'h8000_0010, "cause_ro");
    rd(5'd15, 32'h0000_2020, "prid_ro");
    rd(5'd3, 32'h0, "unimpl");

    // interrupt beats exception and mtc0
    HWInt = 6'b100000; ExcReq = 1;
    ExcCodeIn = 5'd8; EPCIn = 32'h4000;
    WE = 1; A2 = 5'd14; DIn = 32'h1234;
    #1;
    chk("prio_intreq", {31'h0, IntReq}, 32'h1);
    tick();
    idle();
    rd(5'd14, 32'h0000_4000, "prio_epc");
    rd(5'd13, 32'h0000_8000, "prio_cause");
    rd(5'd12, 32'h0000_FC03, "prio_sr");

    // reset overrides everything
    reset_n = 0; HWInt = 6'b000001;
    ExcReq = 1; EXLClr = 1;
    WE = 1; A2 = 5'd12; DIn = 32'h0000_FC01;
    tick();
    reset_n = 1; HWInt = 0;
    idle();
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    chk("rst_intreq", {31'h0, IntReq}, 32'h0);

`ifdef CP0_TIMER_EN
    mtc0(5'd9, 32'hFFFF_FFFE);
    mtc0(5'd11, 32'h0000_0001);
    rd(5'd9, 32'hFFFF_FFFF, "cnt_ff");
    rd(5'd11, 32'h0000_0001, "cmp_rd");
    tick();
    rd(5'd9, 32'h0, "cnt_wrap");
    tick();
    rd(5'd9, 32'h1, "cnt_one");
    tick();
    rd(5'd13, 32'h0, "ip_pre");
    tick();
    rd(5'd13, 32'h0000_8000, "timer_ip");
    mtc0(5'd11, 32'h0);
    tick();
    rd(5'd13, 32'h0, "timer_clr");
`else
    mtc0(5'd9, 32'h5);
    mtc0(5'd11, 32'h7);
    rd(5'd9, 32'h0, "no_count");
    rd(5'd11, 32'h0, "no_compare");
    HWInt = 6'b0;
    tick();
    rd(5'd13, 32'h0, "no_timer_ip");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have parameter PRID_VALUE, default 32'h0000_2020, value returned by PRId (reg 15).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port A1  in  5  mfc0 read register number.
REQ-005 SHALL have port A2  in  5  mtc0 write register number.
REQ-006 SHALL have port DIn  in  32  mtc0 write data.
REQ-007 SHALL have port WE  in  1  mtc0 write enable.
REQ-008 SHALL have port ExcReq  in  1  exception request from the exception-signal bridge.
REQ-009 SHALL have port EPCIn  in  32  victim PC, already BD-adjusted by the bridge.
REQ-010 SHALL have port BDIn  in  1  victim in delay slot.
REQ-011 SHALL have port ExcCodeIn  in  5  exception code (never 0).
REQ-012 SHALL have port HWInt  in  6  external interrupt lines, level-sensitive.
REQ-013 SHALL have port EXLClr  in  1  eret commit pulse.
REQ-014 SHALL have port IntReq  out  1  interrupt taken this cycle.
REQ-015 SHALL have port EPCOut  out  32  current EPC, for eret redirect.
REQ-016 SHALL have port DOut  out  32  mfc0 read data.

Function
REQ-017 SHALL implement SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0, ignore writes.
REQ-018 SHALL implement Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0; Cause not mtc0-writable.
REQ-019 SHALL implement EPC (14), full 32 bits, mtc0-writable; PRId (15) read-only PRID_VALUE.
REQ-020 SHALL drive DOut combinationally from A1; unimplemented numbers read 0; no write bypass (value written visible from next cycle).
REQ-021 SHALL register IP[15:10] <= HWInt (OR timer pending on bit 15) every cycle.
REQ-022 SHALL compute IntReq = |(HWInt_eff & IM) & IE & ~EXL, combinational, using current HWInt_eff (HWInt OR timer pending on bit 5).
REQ-023 SHALL define Take = IntReq | (ExcReq & ~EXL); ExcReq while EXL=1 is ignored.
REQ-024 SHALL on Take: EXL<=1, EPC<=EPCIn, BD<=BDIn, ExcCode<=IntReq ? 0 : ExcCodeIn (interrupt beats exception).
REQ-025 SHALL give Take priority over same-cycle mtc0 (write dropped) and over EXLClr.
REQ-026 SHALL on EXLClr without Take clear EXL; mtc0 same cycle applies, with EXL still cleared.
REQ-027 SHALL output EPCOut = EPC register (no bypass of EPCIn).

Reset
REQ-028 SHALL on reset_n=0 at clk edge clear SR, Cause, EPC, Count, Compare, timer pending; IntReq=0 then; DOut reflects zeroed registers.
REQ-029 SHALL let reset override Take, mtc0 and EXLClr in the same cycle.

Configuration
REQ-030 SHALL, with CP0_TIMER_EN defined, implement Count (9) and Compare (11), both 32-bit, mtc0-writable, readable.
REQ-031 SHALL increment Count by 1 per cycle, wrapping FFFF_FFFF->0; mtc0 to Count loads DIn instead of incrementing.
REQ-032 SHALL set sticky timer pending when Count==Compare and Compare!=0; mtc0 to Compare clears it.
REQ-033 SHALL, without CP0_TIMER_EN, read regs 9/11 as 0, ignore their writes, timer pending constant 0.

Verification
REQ-034 Reset, then mtc0 SR=0000_FC01, HWInt=6'b000001 -> IntReq=1 same cycle; next cycle EXL=1, ExcCode=0, EPC=EPCIn.
REQ-035 EXL=0, ExcReq=1, ExcCodeIn=5'd4, BDIn=1, EPCIn=0000_3004 -> Cause=8000_0010, EPC=0000_3004, SR.EXL=1.
REQ-036 EXL=1, ExcReq=1 -> no state change; then EXLClr=1 -> EXL=0 next cycle.
REQ-037 IntReq and ExcReq and mtc0 EPC=1234 same cycle -> ExcCode=0, EPC=EPCIn, mtc0 dropped.
REQ-038 CP0_TIMER_EN: mtc0 Count=FFFF_FFFE, Compare=0000_0001 -> Count wraps to 0 then 1, IP[15]=1 next cycle; mtc0 Compare clears IP[15].
